// File: rtl/addsub_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_stage_pkg
//  Brief    : Shared op encodings, FSM state type and helpers for addsub_stage.
//  Revision : 1.0 - initial release
// ============================================================================
package addsub_stage_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Accumulating ops take operand A from the running accumulator.
    function automatic logic is_acc_op(input logic [1:0] op);
        return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
    endfunction

endpackage : addsub_stage_pkg
`default_nettype wire

// File: rtl/addsub_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_stage_if
//  Brief    : Request/result handshake bundle for addsub_stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface addsub_stage_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_op, in_a, in_b, acc_clr, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_zero, out_neg, out_ovf
    );

    modport master (
        output in_valid, in_op, in_a, in_b, acc_clr, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_zero, out_neg, out_ovf
    );
endinterface : addsub_stage_if
`default_nettype wire

// File: rtl/addsub_core.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_core
//  Brief    : Combinational WIDTH-bit ripple add/subtract (mode=1 -> a-b).
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_core #(
    parameter int WIDTH = 3
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             mode,
    output logic      [WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  carry_msb
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = mode;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic w_bx;
            assign w_bx       = b[i] ^ mode;
            assign sum[i]     = a[i] ^ w_bx ^ w_c[i];
            assign w_c[i+1]   = (a[i] & w_bx) | (a[i] & w_c[i]) | (w_bx & w_c[i]);
        end
    endgenerate

    assign carry_out = w_c[WIDTH];
    assign carry_msb = w_c[WIDTH-1];

endmodule : addsub_core
`default_nettype wire

// File: rtl/addsub_stage.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_stage
//  Brief    : Issue/capture stage around addsub_core with running accumulator.
//             Status flags are built only when ADDSUB_FLAGS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_stage
    import addsub_stage_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    addsub_stage_if.slave  bus
);
    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic [WIDTH-1:0] w_dp_a;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;
    logic             w_carry_msb;

    assign w_dp_a = is_acc_op(r_op) ? r_acc : r_a;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a         (w_dp_a),
        .b         (r_b),
        .mode      (r_op[0]),
        .sum       (w_sum),
        .carry_out (w_carry_out),
        .carry_msb (w_carry_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.in_op;
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_sum       <= w_sum;
                    r_carry     <= w_carry_out;
                    r_acc       <= w_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
            // Placed last so a clear overrides the EXEC accumulator write.
            if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_carry = r_carry;

`ifdef ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_neg;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
            r_ovf  <= w_carry_msb ^ w_carry_out;
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_neg  = r_neg;
    assign bus.out_ovf  = r_ovf;
`else
    logic w_unused_carry_msb;
    assign w_unused_carry_msb = w_carry_msb;

    assign bus.out_zero = 1'b0;
    assign bus.out_neg  = 1'b0;
    assign bus.out_ovf  = 1'b0;
`endif

endmodule : addsub_stage
`default_nettype wire

// File: tb/tb_addsub_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_stage
//  Brief    : Self-checking bench for addsub_stage against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_stage;
    localparam int W = 3;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   acc_m = 0;

    addsub_stage_if #(.WIDTH(W)) bus ();

    addsub_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result vector layout: {sum, carry, zero, neg, ovf}
    function automatic logic [W+3:0] model(input int a, input int b, input bit m);
        int            r, sa, sb, sr;
        logic [W-1:0]  s;
        logic          c, z, n, v;
        r  = m ? a - b : a + b;
        s  = W'((r + M) % M);
        c  = m ? (a >= b) : (a + b >= M);
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        sr = m ? sa - sb : sa + sb;
        v  = (sr < -(M / 2)) || (sr >= M / 2);
        z  = (s == '0);
        n  = s[W-1];
`ifndef ADDSUB_FLAGS_EN
        z = 1'b0;
        n = 1'b0;
        v = 1'b0;
`endif
        return {s, c, z, n, v};
    endfunction

    task automatic predict(input logic [1:0] op, input int a, input int b,
                           input bit clr_acc, input bit clr_exec,
                           output logic [W+3:0] exp);
        int a_eff;
        if (clr_acc) acc_m = 0;
        a_eff = op[1] ? acc_m : a;
        exp   = model(a_eff, b, op[0]);
        acc_m = clr_exec ? 0 : int'(exp[W+3:4]);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit clr_acc, input bit clr_exec,
                         output logic [W+3:0] obs, output bit ok);
        int n;
        ok          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.acc_clr  = clr_acc;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) ok = 1'b0;
        step();
        bus.in_valid = 1'b0;
        bus.acc_clr  = clr_exec;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) ok = 1'b0;
        step();
        bus.acc_clr = 1'b0;
        if (bus.out_valid !== 1'b1) ok = 1'b0;
        obs = {bus.out_sum, bus.out_carry, bus.out_zero, bus.out_neg, bus.out_ovf};
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+5:0] obs;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_b = '0;
        bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        acc_m = 0;
        obs = {bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry,
               bus.out_zero, bus.out_neg, bus.out_ovf};
        total_cnt++;
        if (obs !== {1'b0, 1'b1, {W{1'b0}}, 4'b0000})
            $display("FAIL reset_state: got %b expected %b", obs, {1'b0, 1'b1, {W{1'b0}}, 4'b0000});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [1:0]   ops [7]   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        int           as  [7]   = '{3, 2, 5, 7, 0, 0, 7};
        int           bs  [7]   = '{2, 3, 5, 3, 6, 1, 7};
        bit           clr [7]   = '{0, 0, 0, 1, 0, 0, 0};
        logic [W+3:0] obs, exp;
        bit           ok;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], W'(as[i]), W'(bs[i]), clr[i], 1'b0, obs, ok);
            predict(ops[i], as[i], bs[i], clr[i], 1'b0, exp);
            total_cnt++;
            if (obs !== exp) $display("FAIL directed_%0d result: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            total_cnt++;
            if (ok !== 1'b1) $display("FAIL directed_%0d handshake: got %b expected 1", i, ok);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [W+3:0] exp1, exp2, obs;
        logic [1:0]   op2;
        logic [W-1:0] a2, b2;
        op2 = 2'($urandom_range(0, 3));
        a2  = W'($urandom_range(0, M - 1));
        b2  = W'($urandom_range(0, M - 1));
        predict(2'b00, 6, 5, 1'b0, 1'b0, exp1);
        predict(op2, int'(a2), int'(b2), 1'b0, 1'b0, exp2);
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = W'(6); bus.in_b = W'(5);
        step();
        bus.in_op = 2'($urandom_range(0, 3));
        bus.in_a  = W'($urandom_range(0, M - 1));
        step();
        for (int c = 0; c < 4; c++) begin
            obs = {bus.out_sum, bus.out_carry, bus.out_zero, bus.out_neg, bus.out_ovf};
            total_cnt++;
            if (obs !== exp1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: got res=%b v=%b rdy=%b expected res=%b v=1 rdy=0",
                         c, obs, bus.out_valid, bus.in_ready, exp1);
            else pass_cnt++;
            bus.in_op = 2'($urandom_range(0, 3));
            bus.in_a  = W'($urandom_range(0, M - 1));
            bus.in_b  = W'($urandom_range(0, M - 1));
            if (c < 3) step();
        end
        bus.in_op = op2; bus.in_a = a2; bus.in_b = b2;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        step();
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL bp_second_accept: got rdy=%b v=%b expected rdy=0 v=0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        step();
        obs = {bus.out_sum, bus.out_carry, bus.out_zero, bus.out_neg, bus.out_ovf};
        total_cnt++;
        if (obs !== exp2 || bus.out_valid !== 1'b1)
            $display("FAIL bp_second_result: got %b v=%b expected %b v=1", obs, bus.out_valid, exp2);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rst_mid_exec();
        logic [W+3:0] obs, exp;
        bit           ok;
        issue(2'b00, W'(3), W'(3), 1'b0, 1'b0, obs, ok);
        predict(2'b00, 3, 3, 1'b0, 1'b0, exp);
        total_cnt++;
        if (obs !== exp || ok !== 1'b1) $display("FAIL rst_pre_op: got %b ok=%b expected %b ok=1", obs, ok, exp);
        else pass_cnt++;
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = W'(1); bus.in_b = W'(1);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        acc_m = 0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== '0 || bus.out_carry !== 1'b0)
            $display("FAIL rst_mid_exec: got v=%b rdy=%b sum=%0d c=%b expected v=0 rdy=1 sum=0 c=0",
                     bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry);
        else pass_cnt++;
        issue(2'b10, W'(0), W'(2), 1'b0, 1'b0, obs, ok);
        predict(2'b10, 0, 2, 1'b0, 1'b0, exp);
        total_cnt++;
        if (obs !== exp || ok !== 1'b1) $display("FAIL rst_acc_cleared: got %b ok=%b expected %b ok=1", obs, ok, exp);
        else pass_cnt++;
    endtask

    task automatic test_acc_clr_exec();
        logic [W+3:0] obs, exp;
        bit           ok;
        issue(2'b00, W'(1), W'(3), 1'b0, 1'b1, obs, ok);
        predict(2'b00, 1, 3, 1'b0, 1'b1, exp);
        total_cnt++;
        if (obs !== exp || ok !== 1'b1) $display("FAIL clr_exec_op: got %b ok=%b expected %b ok=1", obs, ok, exp);
        else pass_cnt++;
        issue(2'b10, W'(5), W'(1), 1'b0, 1'b0, obs, ok);
        predict(2'b10, 5, 1, 1'b0, 1'b0, exp);
        total_cnt++;
        if (obs !== exp || ok !== 1'b1) $display("FAIL clr_exec_follow: got %b ok=%b expected %b ok=1", obs, ok, exp);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W+3:0] obs, exp;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        bit           ok, clr, clr_x;
        for (int i = 0; i < 40; i++) begin
            op    = 2'($urandom_range(0, 3));
            a     = W'($urandom_range(0, M - 1));
            b     = W'($urandom_range(0, M - 1));
            clr   = ($urandom_range(0, 7) == 0);
            clr_x = ($urandom_range(0, 9) == 0);
            issue(op, a, b, clr, clr_x, obs, ok);
            predict(op, int'(a), int'(b), clr, clr_x, exp);
            total_cnt++;
            if (obs !== exp || ok !== 1'b1)
                $display("FAIL random_%0d op=%0d a=%0d b=%0d: got %b ok=%b expected %b ok=1",
                         i, op, a, b, obs, ok, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_rst_mid_exec();
        test_acc_clr_exec();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_addsub_stage
`default_nettype wire
